// File: rtl/flow_rd_scheduler.sv
// -----------------------------------------------------------------------------
// flow_rd_scheduler
//
// Purpose:
//   Tracks how many complete packets are waiting per flow and hands the read
//   engine one flow at a time. A packet is counted when the write side accepts
//   its last beat. It is uncounted when the read engine accepts the grant. Only
//   one packet is in flight: after a grant is accepted the scheduler waits for
//   the read side to finish that packet before it offers another grant.
//
// Parameters:
//   FLOWS_W  flow-number width; NUM_FLOWS = 2**FLOWS_W
//   CNT_W    width of each per-flow pending-packet counter (saturating)
//
// Ports:
//   clk           in   single clock, rising edge
//   rstn          in   asynchronous active-low reset
//   sched_en      in   high permits new grants
//   wr_pkt_done   in   pulse: write side accepted a packet's last beat
//   wr_pkt_flow   in   flow of that packet
//   gnt_valid     out  grant offered to the read engine
//   gnt_flow      out  granted flow, stable while gnt_valid is high
//   gnt_ready     in   read engine accepts the grant (with gnt_valid)
//   rd_pkt_done   in   pulse: read side finished the granted packet
//   flow_pending  out  bit i set while counter i is nonzero
//   err_ovf       out  sticky: increment attempted on a saturated counter
//   err_unexp     out  sticky: rd_pkt_done seen while not BUSY
//
// Configuration macro:
//   FLOW_SCHED_STRICT_PRIO_EN  when defined, the lowest-index pending flow
//                              always wins and no round-robin pointer exists.
//                              When undefined, round-robin arbitration is used.
// -----------------------------------------------------------------------------
module flow_rd_scheduler #(
  parameter int unsigned FLOWS_W = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      sched_en,
  input  logic                      wr_pkt_done,
  input  logic [FLOWS_W-1:0]        wr_pkt_flow,
  output logic                      gnt_valid,
  output logic [FLOWS_W-1:0]        gnt_flow,
  input  logic                      gnt_ready,
  input  logic                      rd_pkt_done,
  output logic [(2**FLOWS_W)-1:0]   flow_pending,
  output logic                      err_ovf,
  output logic                      err_unexp
);

  localparam int unsigned NUM_FLOWS = 2**FLOWS_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  // Returns {found, flow}: the first pending flow at or after ptr, scanning
  // upward modulo NUM_FLOWS. The scan runs from the farthest offset down to
  // offset 0 so the nearest pending flow is the last one written.
  function automatic logic [FLOWS_W:0] pick_flow(
    input logic [NUM_FLOWS-1:0] pend,
    input logic [FLOWS_W-1:0]   ptr
  );
    logic [FLOWS_W:0]   res;
    logic [FLOWS_W-1:0] idx;
    res = {(FLOWS_W+1){1'b0}};
    for (int i = NUM_FLOWS - 1; i >= 0; i--) begin
      idx = ptr + FLOWS_W'(i);
      if (pend[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_e             state_q, state_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [FLOWS_W-1:0] gnt_flow_q, gnt_flow_d;
  logic               err_ovf_q, err_ovf_d;
  logic               err_unexp_q, err_unexp_d;
  logic [CNT_W-1:0]   cnt_q [NUM_FLOWS];
  logic [CNT_W-1:0]   cnt_d [NUM_FLOWS];

  logic               accept_s;
  logic               ovf_hit_s;
  logic [FLOWS_W:0]   pick_s;
  logic [NUM_FLOWS-1:0] pending_s;

  assign accept_s = (state_q == ST_GRANT) && gnt_valid_q && gnt_ready;

  // Pending flags come straight from the registered counters. An increment
  // therefore becomes visible to the IDLE evaluation one cycle later.
  always_comb begin
    pending_s = {NUM_FLOWS{1'b0}};
    for (int f = 0; f < NUM_FLOWS; f++) begin
      pending_s[f] = (cnt_q[f] != {CNT_W{1'b0}});
    end
  end

`ifdef FLOW_SCHED_STRICT_PRIO_EN
  // Fixed priority: scanning from flow 0 yields the lowest-index pending flow.
  assign pick_s = pick_flow(pending_s, {FLOWS_W{1'b0}});
`else
  logic [FLOWS_W-1:0] rr_ptr_q, rr_ptr_d;

  // After an accepted grant the search starts just past the granted flow.
  // The wrap from NUM_FLOWS-1 to 0 comes from the FLOWS_W-bit add.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept_s) begin
      rr_ptr_d = gnt_flow_q + FLOWS_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q <= {FLOWS_W{1'b0}};
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign pick_s = pick_flow(pending_s, rr_ptr_q);
`endif

  // Per-flow counter next state. An increment and a decrement on the same flow
  // cancel. An increment on a saturated counter is dropped and flagged. A
  // decrement of zero cannot happen, because only a pending flow is ever
  // granted; the zero check is a guard against underflow.
  always_comb begin
    logic inc_v;
    logic dec_v;
    ovf_hit_s = 1'b0;
    inc_v     = 1'b0;
    dec_v     = 1'b0;
    for (int f = 0; f < NUM_FLOWS; f++) begin
      inc_v    = wr_pkt_done && (wr_pkt_flow == FLOWS_W'(f));
      dec_v    = accept_s && (gnt_flow_q == FLOWS_W'(f));
      cnt_d[f] = cnt_q[f];
      if (inc_v && !dec_v) begin
        if (cnt_q[f] == CNT_MAX) begin
          ovf_hit_s = 1'b1;
          cnt_d[f]  = cnt_q[f];
        end else begin
          cnt_d[f]  = cnt_q[f] + CNT_W'(1);
        end
      end else if (dec_v && !inc_v && (cnt_q[f] != {CNT_W{1'b0}})) begin
        cnt_d[f] = cnt_q[f] - CNT_W'(1);
      end else begin
        cnt_d[f] = cnt_q[f];
      end
    end
  end

  // Per-flow pending-packet counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        cnt_q[f] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        cnt_q[f] <= cnt_d[f];
      end
    end
  end

  // Scheduler FSM next state and registered grant outputs.
  // The grant flow is captured on IDLE->GRANT and held, whatever sched_en does,
  // until the read engine accepts it.
  always_comb begin
    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    gnt_flow_d  = gnt_flow_q;
    case (state_q)
      ST_IDLE: begin
        if (sched_en && pick_s[FLOWS_W]) begin
          state_d     = ST_GRANT;
          gnt_valid_d = 1'b1;
          gnt_flow_d  = pick_s[FLOWS_W-1:0];
        end else begin
          state_d     = ST_IDLE;
          gnt_valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (accept_s) begin
          state_d     = ST_BUSY;
          gnt_valid_d = 1'b0;
        end else begin
          state_d     = ST_GRANT;
          gnt_valid_d = 1'b1;
        end
      end
      ST_BUSY: begin
        gnt_valid_d = 1'b0;
        if (rd_pkt_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // Sticky error flags. A read completion outside BUSY is only recorded and
  // causes no state change.
  always_comb begin
    err_ovf_d   = err_ovf_q | ovf_hit_s;
    err_unexp_d = err_unexp_q | (rd_pkt_done && (state_q != ST_BUSY));
  end

  // FSM, grant and error registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      gnt_valid_q <= 1'b0;
      gnt_flow_q  <= {FLOWS_W{1'b0}};
      err_ovf_q   <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_flow_q  <= gnt_flow_d;
      err_ovf_q   <= err_ovf_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  assign gnt_valid    = gnt_valid_q;
  assign gnt_flow     = gnt_flow_q;
  assign flow_pending = pending_s;
  assign err_ovf      = err_ovf_q;
  assign err_unexp    = err_unexp_q;

endmodule
